// File: rtl/minterm_sweep_ctrl.sv
// Exhaustive 32-vector sweep of a 5-input (s,a,b,c,d) datapath against the F_TT/G_TT truth tables.
// Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module minterm_sweep_ctrl #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] F_TT          = 16'h0000,
    parameter logic [15:0] G_TT          = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] drv_abcd,
    output logic       drv_s,
    input  logic       dut_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] mismatch_cnt,
    output logic       fail_valid,
    output logic [4:0] first_fail
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [4:0] idx;
    logic [7:0] settleCnt;
    logic       expBit;
    logic       isMis;
    logic       lastVec;
    logic [5:0] nextCnt;

    // Drivers come straight from the vector register so they hold between sweeps.
    assign drv_s    = idx[4];
    assign drv_abcd = idx[3:0];

    assign expBit  = idx[4] ? G_TT[idx[3:0]] : F_TT[idx[3:0]];
    assign isMis   = dut_o != expBit;
    assign nextCnt = mismatch_cnt + 6'(isMis);
`ifdef SWEEP_STOP_ON_FAIL_EN
    assign lastVec = (idx == 5'd31) || isMis;
`else
    assign lastVec = (idx == 5'd31);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            settleCnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx          <= '0;
                        settleCnt    <= '0;
                        mismatch_cnt <= '0;
                        fail_valid   <= 1'b0;
                        first_fail   <= '0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    settleCnt <= settleCnt + 8'd1;
                    if (settleCnt == SETTLE_LAST)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    if (isMis) begin
                        mismatch_cnt <= nextCnt;
                        if (!fail_valid) begin
                            first_fail <= idx;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (lastVec) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (nextCnt == 6'd0);
                        state <= DONE;
                    end else begin
                        idx       <= idx + 5'd1;
                        settleCnt <= '0;
                        state     <= SETTLE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Scoreboard bench: two sweep controllers (SETTLE 4 / SETTLE 1) driving behavioural datapaths
// with injectable faults; a per-instance monitor checks each done pulse against queued expectations.
module tb_minterm_sweep_ctrl;

`ifdef SWEEP_STOP_ON_FAIL_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif
    localparam logic [15:0] FA = 16'hA5C3;
    localparam logic [15:0] GA = 16'h3C96;

    typedef struct {
        int lat; int cnt; int pss; int fv; int ff; int last; int steps;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, startA, startB;
    logic [3:0]  abcdA, abcdB;
    logic        sA, sB, oA, oB, busyA, busyB, doneA, doneB, passA, passB, fvA, fvB;
    logic [5:0]  cntA, cntB;
    logic [4:0]  ffA, ffB;
    logic [31:0] maskA;
    logic        tie0B;

    minterm_sweep_ctrl #(.SETTLE_CYCLES(4), .F_TT(FA), .G_TT(GA)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .drv_abcd(abcdA), .drv_s(sA), .dut_o(oA),
        .busy(busyA), .done(doneA), .pass(passA), .mismatch_cnt(cntA), .fail_valid(fvA),
        .first_fail(ffA));

    minterm_sweep_ctrl #(.SETTLE_CYCLES(1), .F_TT(16'h0000), .G_TT(16'hFFFF)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .drv_abcd(abcdB), .drv_s(sB), .dut_o(oB),
        .busy(busyB), .done(doneB), .pass(passB), .mismatch_cnt(cntB), .fail_valid(fvB),
        .first_fail(ffB));

    // Behavioural datapaths; maskA flips the output on chosen vectors.
    assign oA = (sA ? GA[abcdA] : FA[abcdA]) ^ maskA[{sA, abcdA}];
    assign oB = tie0B ? 1'b0 : sB;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nVec = 0, nMis = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    exp_t qA[$], qB[$];
    exp_t eA, eB;
    int startCycA = 0, startCycB = 0, stepsA = 0, stepsB = 0;
    logic [4:0] prevA = '0, prevB = '0;
    logic prevBusyA = 1'b0, prevBusyB = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) stepsA = 0;
        else begin
            if (busyA && prevBusyA && {sA, abcdA} != prevA)
                stepsA += ({sA, abcdA} == prevA + 5'd1) ? 1 : 100;
            if (doneA) begin
                if (qA.size() == 0) chk("A spurious done", doneA, 0);
                else begin
                    eA = qA.pop_front();
                    chk("A latency", cyc - startCycA, eA.lat);
                    chk("A mismatch_cnt", cntA, eA.cnt);
                    chk("A pass", passA, eA.pss);
                    chk("A fail_valid", fvA, eA.fv);
                    chk("A first_fail", ffA, eA.ff);
                    chk("A last vector", {sA, abcdA}, eA.last);
                    chk("A vector steps", stepsA, eA.steps);
                    chk("A busy in done", busyA, 0);
                end
                stepsA = 0;
            end
        end
        prevA = {sA, abcdA};
        prevBusyA = busyA;
    end

    always @(negedge clk) begin
        if (!rst_n) stepsB = 0;
        else begin
            if (busyB && prevBusyB && {sB, abcdB} != prevB)
                stepsB += ({sB, abcdB} == prevB + 5'd1) ? 1 : 100;
            if (doneB) begin
                if (qB.size() == 0) chk("B spurious done", doneB, 0);
                else begin
                    eB = qB.pop_front();
                    chk("B latency", cyc - startCycB, eB.lat);
                    chk("B mismatch_cnt", cntB, eB.cnt);
                    chk("B pass", passB, eB.pss);
                    chk("B fail_valid", fvB, eB.fv);
                    chk("B first_fail", ffB, eB.ff);
                    chk("B last vector", {sB, abcdB}, eB.last);
                    chk("B vector steps", stepsB, eB.steps);
                end
                stepsB = 0;
            end
        end
        prevB = {sB, abcdB};
        prevBusyB = busyB;
    end

    task automatic zerosA(input string tag);
        chk({tag, " drv"}, {sA, abcdA}, 0);
        chk({tag, " busy"}, busyA, 0);
        chk({tag, " done"}, doneA, 0);
        chk({tag, " pass"}, passA, 0);
        chk({tag, " cnt"}, cntA, 0);
        chk({tag, " fail_valid"}, fvA, 0);
        chk({tag, " first_fail"}, ffA, 0);
    endtask

    // Start a sweep on A; optionally pulse start again at cycles 10, 159 and during DONE.
    task automatic runA(input logic [31:0] mask, input bit pulses, input exp_t e);
        int t;
        maskA = mask;
        @(posedge clk); #1;
        startA = 1'b1; startCycA = cyc + 1; qA.push_back(e);
        t = 0;
        do begin
            @(posedge clk); #1;
            startA = pulses && (cyc - startCycA == 9 || cyc - startCycA == 158);
            t++;
        end while (!doneA && t < 400);
        if (t >= 400) chk("A done timeout", doneA, 1);
        startA = pulses;
        @(posedge clk); #1;
        startA = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("A hold drivers", {sA, abcdA}, e.last);
        chk("A idle after sweep", busyA, 0);
    endtask

    task automatic runB(input bit tie0, input exp_t e);
        int t;
        tie0B = tie0;
        @(posedge clk); #1;
        startB = 1'b1; startCycB = cyc + 1; qB.push_back(e);
        t = 0;
        do begin
            @(posedge clk); #1;
            startB = 1'b0;
            t++;
        end while (!doneB && t < 200);
        if (t >= 200) chk("B done timeout", doneB, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("B idle after sweep", busyB, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; startA = 1'b0; startB = 1'b0; maskA = '0; tie0B = 1'b0;
        startA = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        zerosA("reset");
        chk("reset B busy", busyB, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; startA = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no sweep without start", busyA, 0);

        runA(32'h0000_0000, 1'b0, '{160, 0, 1, 0, 0, 31, 31});
        runA(32'h0000_0020, 1'b0, '{S ? 30 : 160, 1, 0, 1, 5, S ? 5 : 31, S ? 5 : 31});
        runA(32'h8010_0020, 1'b0, '{S ? 30 : 160, S ? 1 : 3, 0, 1, 5, S ? 5 : 31, S ? 5 : 31});
        runA(32'h0010_0000, 1'b0, '{S ? 105 : 160, 1, 0, 1, 20, S ? 20 : 31, S ? 20 : 31});
        runA(32'hFFFF_FFFF, 1'b0, '{S ? 5 : 160, S ? 1 : 32, 0, 1, 0, S ? 0 : 31, S ? 0 : 31});
        runA(32'h8000_0000, 1'b0, '{160, 1, 0, 1, 31, 31, 31});
        runA(32'h0000_0000, 1'b1, '{160, 0, 1, 0, 0, 31, 31});

        // Reset for one edge, 50 cycles into a sweep.
        maskA = '0;
        @(posedge clk); #1;
        startA = 1'b1; startCycA = cyc + 1;
        @(posedge clk); #1;
        startA = 1'b0;
        while (cyc - startCycA < 49) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        zerosA("mid-sweep reset");
        repeat (5) @(posedge clk);
        #1;
        chk("idle after mid reset", busyA, 0);
        runA(32'h0000_0000, 1'b0, '{160, 0, 1, 0, 0, 31, 31});

        runB(1'b0, '{64, 0, 1, 0, 0, 31, 31});
        runB(1'b1, '{S ? 34 : 64, S ? 1 : 16, 0, 1, 16, S ? 16 : 31, S ? 16 : 31});
        runB(1'b0, '{64, 0, 1, 0, 0, 31, 31});

        chk("A queue drained", qA.size(), 0);
        chk("B queue drained", qB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/minterm_sweep_ctrl.md
MINTERM_SWEEP_CTRL -- requirements
Module: minterm_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles the drivers hold a vector before sampling; legal range 1..255.
REQ-002 Parameter F_TT, default 16'h0000: expected output when s=0, bit index = {a,b,c,d}.
REQ-003 Parameter G_TT, default 16'h0000: expected output when s=1, bit index = {a,b,c,d}.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request a sweep; sampled only in IDLE.
REQ-007 drv_abcd  output  4  drives a,b,c,d of the minimized-logic datapath; bit 3 = a.
REQ-008 drv_s  output  1  drives the datapath select s.
REQ-009 dut_o  input  1  datapath output o.
REQ-010 busy  output  1  high in SETTLE and SAMPLE.
REQ-011 done  output  1  one-cycle pulse at the end of a sweep.
REQ-012 pass  output  1  sweep verdict, held until the next accepted start.
REQ-013 mismatch_cnt  output  6  mismatches in the current or last sweep.
REQ-014 fail_valid  output  1  high once any mismatch has been recorded.
REQ-015 first_fail  output  5  {s,a,b,c,d} of the first mismatching vector.

Function
REQ-016 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-017 Vector index idx is 5 bits; drv_s = idx[4], drv_abcd = idx[3:0]; order is 0..31.
REQ-018 IDLE with start=1: idx←0, settle counter←0, mismatch_cnt←0, fail_valid←0, first_fail←0, pass←0; go to SETTLE.
REQ-019 SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles, go to SAMPLE.
REQ-020 SAMPLE: expected = idx[4] ? G_TT[idx[3:0]] : F_TT[idx[3:0]]; on a dut_o mismatch, increment mismatch_cnt.
REQ-021 A mismatch with fail_valid=0 loads first_fail←idx and sets fail_valid.
REQ-022 SAMPLE, idx≠31: idx←idx+1, counter←0, return to SETTLE; drivers change on that same edge.
REQ-023 SAMPLE, idx=31: go to DONE.
REQ-024 DONE lasts exactly one cycle: done=1, pass←(final mismatch_cnt==0), then IDLE.
REQ-025 Per-vector time is SETTLE_CYCLES+1 cycles; full sweep is 32×(SETTLE_CYCLES+1) cycles from the start edge to the done cycle.
REQ-026 start is ignored outside IDLE, including during DONE.
REQ-027 Drivers hold the last vector in DONE and IDLE until the next accepted start.
REQ-028 mismatch_cnt cannot overflow, because its maximum is 32.

Reset
REQ-029 rst_n=0 at an edge forces IDLE from any state, including mid-sweep.
REQ-030 Reset clears idx, counter, drv_abcd, drv_s, busy, done, pass, mismatch_cnt, fail_valid and first_fail to 0.
REQ-031 After reset deassertion, no sweep starts without a new start.

Configuration
REQ-032 Macro SWEEP_STOP_ON_FAIL_EN defined: a SAMPLE cycle with a mismatch goes directly to DONE regardless of idx, with pass=0 and mismatch_cnt=1.
REQ-033 Macro SWEEP_STOP_ON_FAIL_EN undefined: all 32 vectors are always applied.

Verification
REQ-034 SETTLE_CYCLES=4, correct behavioural datapath, start at cycle 0 -> done at cycle 160, pass=1, mismatch_cnt=0, fail_valid=0.
REQ-035 Same setup with dut_o inverted only for idx 5 -> mismatch_cnt=1, first_fail=5'd5, fail_valid=1, pass=0.
REQ-036 F_TT=16'h0000, G_TT=16'hFFFF, dut_o tied 0, macro undefined -> mismatch_cnt=16, first_fail=5'd16; with macro defined -> done at cycle 85, mismatch_cnt=1.
REQ-037 rst_n low for one edge at cycle 50 of a sweep -> next cycle all outputs 0 in IDLE; a new start gives a full 160-cycle sweep.
REQ-038 start pulsed at cycles 10 and 159 during a sweep -> no restart, idx sequence is unchanged; with SETTLE_CYCLES=1 the sweep takes 64 cycles.
